// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the pe_dot dot-product engine.
//   pe_state_t   control FSM state encoding
//   PE_*         default parameter values for pe_dot
package pe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } pe_state_t;

    localparam int PE_LANES    = 4;
    localparam int PE_W_BITS   = 4;
    localparam int PE_A_BITS   = 8;
    localparam int PE_ACC_LEN  = 16;
    localparam int PE_ACC_BITS = 32;

endpackage

// File: rtl/pe_mac_lane.sv
// pe_mac_lane: one weight x activation multiplier with a registered product.
//   clk, reset_n   clock, async active-low reset
//   en             capture the product this cycle
//   clr            synchronous zero of the product register (wins over en)
//   is_signed      1: operands are two's complement, 0: unsigned
//   weight         W_BITS operand
//   activation     A_BITS operand
//   product        signed product, one bit wider than W_BITS+A_BITS so that
//                  both the unsigned and signed ranges fit
module pe_mac_lane #(
    parameter int W_BITS = 4,
    parameter int A_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       is_signed,
    input  logic [W_BITS-1:0]          weight,
    input  logic [A_BITS-1:0]          activation,
    output logic signed [W_BITS+A_BITS:0] product
);

    localparam int P_BITS = W_BITS + A_BITS + 1;

    logic signed [W_BITS:0] w_ext;
    logic signed [A_BITS:0] a_ext;
    logic signed [P_BITS-1:0] full;

    // One extra top bit per operand: a copy of the MSB in signed mode, zero
    // in unsigned mode, so a single signed multiplier serves both modes.
    assign w_ext = {is_signed & weight[W_BITS-1], weight};
    assign a_ext = {is_signed & activation[A_BITS-1], activation};
    assign full  = P_BITS'(w_ext) * P_BITS'(a_ext);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            product <= '0;
        end else if (clr) begin
            product <= '0;
        end else if (en) begin
            product <= full;
        end
    end

endmodule

// File: rtl/pe_dot.sv
// pe_dot: LANES-wide dot-product accumulator over windows of ACC_LEN beats.
//   clk, reset_n        clock, async active-low reset
//   i_valid / o_ready   input beat handshake (i_weight, i_activation, i_signed)
//   i_signed            operand mode, sampled on the first beat of a window
//   i_clear             synchronous abort of the current window
//   o_valid / i_ready   result handshake (o_calculated, o_overflow)
// Build option: define PE_DOT_SATURATE_EN to clamp the accumulator and report
// o_overflow; otherwise it wraps modulo 2^ACC_BITS and o_overflow is 0.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | counter 0, stage 1 empty
// ST_ACCUM | window open or last beat still in stage 1
// ST_HOLD  | pipeline frozen, result waiting for i_ready
module pe_dot
    import pe_pkg::*;
#(
    parameter int LANES    = PE_LANES,
    parameter int W_BITS   = PE_W_BITS,
    parameter int A_BITS   = PE_A_BITS,
    parameter int ACC_LEN  = PE_ACC_LEN,
    parameter int ACC_BITS = PE_ACC_BITS
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [LANES*W_BITS-1:0]    i_weight,
    input  logic [LANES*A_BITS-1:0]    i_activation,
    input  logic                       i_signed,
    input  logic                       i_clear,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [ACC_BITS-1:0]        o_calculated,
    output logic                       o_overflow
);

    localparam int P_BITS   = W_BITS + A_BITS + 1;
    localparam int LS_BITS  = P_BITS + $clog2(LANES) + 1;
    localparam int CNT_BITS = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    pe_state_t             state;
    logic [CNT_BITS-1:0]   cnt;
    logic                  mode_q;
    logic                  s1_valid;
    logic                  s1_last;
    logic [ACC_BITS-1:0]   acc;
    logic [ACC_BITS-1:0]   acc_next;
    logic signed [P_BITS-1:0]  prod [LANES];
    logic signed [LS_BITS-1:0] lane_sum;

    logic advance;
    logic accept;
    logic last_beat;
    logic mode_beat;
    logic lane_en;

    assign advance   = !(o_valid && !i_ready);
    assign o_ready   = advance || i_clear;
    assign accept    = i_valid && advance && !i_clear;
    assign last_beat = (cnt == CNT_BITS'(ACC_LEN - 1));
    assign mode_beat = (cnt == '0) ? i_signed : mode_q;
    // Lanes sit still between windows when nothing is offered.
    assign lane_en   = advance && (i_valid || state != ST_IDLE);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pe_mac_lane #(
            .W_BITS (W_BITS),
            .A_BITS (A_BITS)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .en         (lane_en),
            .clr        (i_clear),
            .is_signed  (mode_beat),
            .weight     (i_weight[k*W_BITS +: W_BITS]),
            .activation (i_activation[k*A_BITS +: A_BITS]),
            .product    (prod[k])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + LS_BITS'(prod[k]);
        end
    end

`ifdef PE_DOT_SATURATE_EN
    localparam int SUM_BITS = ACC_BITS + LS_BITS;
    localparam logic signed [SUM_BITS-1:0] HI_U =
        {{(SUM_BITS-ACC_BITS){1'b0}}, {ACC_BITS{1'b1}}};
    localparam logic signed [SUM_BITS-1:0] HI_S =
        {{(SUM_BITS-ACC_BITS+1){1'b0}}, {(ACC_BITS-1){1'b1}}};
    localparam logic signed [SUM_BITS-1:0] LO_S =
        {{(SUM_BITS-ACC_BITS+1){1'b1}}, {(ACC_BITS-1){1'b0}}};

    logic                      s1_signed;
    logic                      ovf_acc;
    logic                      sat_hit;
    logic signed [SUM_BITS-1:0] acc_ext;
    logic signed [SUM_BITS-1:0] sum_raw;

    // Sum in a wide signed domain, then clamp to the window mode's range.
    always_comb begin
        acc_ext  = s1_signed ? {{(SUM_BITS-ACC_BITS){acc[ACC_BITS-1]}}, acc}
                             : {{(SUM_BITS-ACC_BITS){1'b0}}, acc};
        sum_raw  = acc_ext + SUM_BITS'(lane_sum);
        acc_next = sum_raw[ACC_BITS-1:0];
        sat_hit  = 1'b0;
        if (s1_signed && sum_raw > HI_S) begin
            acc_next = HI_S[ACC_BITS-1:0];
            sat_hit  = 1'b1;
        end else if (!s1_signed && sum_raw > HI_U) begin
            acc_next = HI_U[ACC_BITS-1:0];
            sat_hit  = 1'b1;
        end else if (s1_signed && sum_raw < LO_S) begin
            acc_next = LO_S[ACC_BITS-1:0];
            sat_hit  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_signed  <= 1'b0;
            ovf_acc    <= 1'b0;
            o_overflow <= 1'b0;
        end else if (i_clear) begin
            s1_signed  <= 1'b0;
            ovf_acc    <= 1'b0;
            o_overflow <= 1'b0;
        end else if (advance) begin
            s1_signed <= mode_beat;
            if (s1_valid) begin
                if (s1_last) begin
                    o_overflow <= ovf_acc | sat_hit;
                    ovf_acc    <= 1'b0;
                end else begin
                    ovf_acc <= ovf_acc | sat_hit;
                end
            end
        end
    end
`else
    always_comb acc_next = acc + ACC_BITS'(lane_sum);

    assign o_overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            mode_q       <= 1'b0;
            s1_valid     <= 1'b0;
            s1_last      <= 1'b0;
            acc          <= '0;
            o_valid      <= 1'b0;
            o_calculated <= '0;
        end else if (i_clear) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            mode_q   <= 1'b0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            acc      <= '0;
            o_valid  <= 1'b0;
        end else if (advance) begin
            s1_valid <= accept;
            s1_last  <= accept && last_beat;
            if (accept) begin
                cnt <= last_beat ? '0 : cnt + CNT_BITS'(1);
                if (cnt == '0) begin
                    mode_q <= i_signed;
                end
            end
            // Either no result is pending or it is being taken this edge.
            o_valid <= s1_valid && s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    o_calculated <= acc_next;
                    acc          <= '0;
                end else begin
                    acc <= acc_next;
                end
            end
            state <= (accept || cnt != '0) ? ST_ACCUM : ST_IDLE;
        end else begin
            state <= ST_HOLD;
        end
    end

endmodule

// File: tb/tb_pe_dot.sv
// tb_pe_dot: self-checking bench for pe_dot (defaults plus an ACC_BITS=16 copy
// sharing the same stimulus). Honours PE_DOT_SATURATE_EN for expectations.
module tb_pe_dot;

    typedef logic [15:0] wwin_t [16];
    typedef logic [31:0] awin_t [16];

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_signed = 1'b0;
    logic        i_clear = 1'b0;
    logic        i_ready = 1'b1;
    logic [15:0] i_weight = '0;
    logic [31:0] i_activation = '0;

    logic        o_ready, o_valid, o_overflow;
    logic [31:0] o_calculated;
    logic        o_ready16, o_valid16, o_overflow16;
    logic [15:0] o_calc16;

    int tests = 0;
    int fails = 0;
    int n_acc = 0;

    logic [31:0] res_q [$];
    logic        ovf_q [$];
    logic [15:0] res16_q [$];
    logic        ovf16_q [$];

    always #5 clk = ~clk;

    pe_dot u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_weight     (i_weight),
        .i_activation (i_activation),
        .i_signed     (i_signed),
        .i_clear      (i_clear),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_calculated (o_calculated),
        .o_overflow   (o_overflow)
    );

    pe_dot #(.ACC_BITS(16)) u_dut16 (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready16),
        .i_weight     (i_weight),
        .i_activation (i_activation),
        .i_signed     (i_signed),
        .i_clear      (i_clear),
        .o_valid      (o_valid16),
        .i_ready      (i_ready),
        .o_calculated (o_calc16),
        .o_overflow   (o_overflow16)
    );

    // Inputs change only at negedge; a result seen here is taken at the next posedge.
    always begin
        @(negedge clk);
        #1;
        if (reset_n && o_valid && i_ready) begin
            res_q.push_back(o_calculated);
            ovf_q.push_back(o_overflow);
        end
        if (reset_n && o_valid16 && i_ready) begin
            res16_q.push_back(o_calc16);
            ovf16_q.push_back(o_overflow16);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: sum of lane products over the window, per-beat clamp when saturating.
    function automatic void model_win(input wwin_t w, input awin_t a, input bit sgn,
                                      input int bits, output longint res, output bit ovf);
        longint acc, hi, lo, mask;
        int wi, ai;
        mask = (longint'(1) << bits) - 1;
        hi   = sgn ? (longint'(1) << (bits - 1)) - 1 : mask;
        lo   = sgn ? -(longint'(1) << (bits - 1)) : 0;
        acc  = 0;
        ovf  = 1'b0;
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 4; k++) begin
                wi = int'(w[b][k*4 +: 4]);
                ai = int'(a[b][k*8 +: 8]);
                if (sgn && wi > 7)   wi -= 16;
                if (sgn && ai > 127) ai -= 256;
                acc += longint'(wi * ai);
            end
`ifdef PE_DOT_SATURATE_EN
            if (acc > hi) begin acc = hi; ovf = 1'b1; end
            if (acc < lo) begin acc = lo; ovf = 1'b1; end
`endif
        end
        res = acc & mask;
    endfunction

    task automatic gen_window(output wwin_t w, output awin_t a);
        for (int b = 0; b < 16; b++) begin
            w[b] = 16'($urandom);
            a[b] = $urandom;
        end
    endtask

    task automatic clear_q();
        res_q.delete();
        ovf_q.delete();
        res16_q.delete();
        ovf16_q.delete();
    endtask

    task automatic send_beat(input logic [15:0] w, input logic [31:0] a, input bit s);
        int guard;
        @(negedge clk);
        i_valid = 1'b1;
        i_weight = w;
        i_activation = a;
        i_signed = s;
        #1;
        guard = 0;
        while (!o_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            tests++; fails++;
            $display("FAIL send_timeout: o_ready=%0b required 1", o_ready);
        end
        @(posedge clk);
        n_acc++;
    endtask

    task automatic idle();
        @(negedge clk);
        i_valid = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic wait_results(input int n, output bit ok);
        int guard;
        guard = 0;
        while (res_q.size() < n && guard < 400) begin
            @(negedge clk);
            #2;
            guard++;
        end
        ok = (res_q.size() >= n) && (res16_q.size() >= n);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL result_timeout: got %0d results required %0d", res_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (o_valid !== 1'b0)       begin fails++; $display("FAIL rst_o_valid: got %b required 0", o_valid); end
        tests++; if (o_calculated !== 32'd0) begin fails++; $display("FAIL rst_o_calc: got %h required 0", o_calculated); end
        tests++; if (o_overflow !== 1'b0)    begin fails++; $display("FAIL rst_o_ovf: got %b required 0", o_overflow); end
        tests++; if (o_ready !== 1'b1)       begin fails++; $display("FAIL rst_o_ready: got %b required 1", o_ready); end
        tests++; if (o_ready16 !== 1'b1 || o_valid16 !== 1'b0) begin fails++; $display("FAIL rst_dut16: ready %b valid %b required 1 0", o_ready16, o_valid16); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_unsigned_ramp();
        clear_q();
        for (int b = 0; b < 16; b++) send_beat(16'h1111, {4{8'(b + 1)}}, 1'b0);
        #1;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL ramp_early_valid: got %b required 0", o_valid); end
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL ramp_latency: o_valid %b required 1", o_valid); end
        tests++; if (o_calculated !== 32'd544) begin fails++; $display("FAIL ramp_sum: got %0d required 544", o_calculated); end
        tests++; if (o_overflow !== 1'b0) begin fails++; $display("FAIL ramp_ovf: got %b required 0", o_overflow); end
        @(posedge clk);
        #1;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL ramp_one_cycle: o_valid %b required 0", o_valid); end
    endtask

    task automatic test_signed();
        bit ok;
        clear_q();
        for (int b = 0; b < 16; b++) send_beat(16'hFFFF, 32'h7F7F7F7F, 1'b1);
        idle();
        wait_results(1, ok);
        if (ok) begin
            tests++; if (res_q[0] !== 32'hFFFFE040) begin fails++; $display("FAIL signed_sum: got %h required FFFFE040", res_q[0]); end
            tests++; if (ovf_q[0] !== 1'b0) begin fails++; $display("FAIL signed_ovf: got %b required 0", ovf_q[0]); end
            tests++; if (res16_q[0] !== 16'hE040) begin fails++; $display("FAIL signed_sum16: got %h required E040", res16_q[0]); end
        end
    endtask

    task automatic test_acc16();
        bit ok;
        logic [15:0] exp16;
        logic        expo;
`ifdef PE_DOT_SATURATE_EN
        exp16 = 16'hFFFF; expo = 1'b1;
`else
        exp16 = 16'hBE40; expo = 1'b0;
`endif
        clear_q();
        for (int b = 0; b < 16; b++) send_beat(16'h7777, 32'hFFFFFFFF, 1'b0);
        idle();
        wait_results(1, ok);
        if (ok) begin
            tests++; if (res16_q[0] !== exp16) begin fails++; $display("FAIL acc16_sum: got %h required %h", res16_q[0], exp16); end
            tests++; if (ovf16_q[0] !== expo)  begin fails++; $display("FAIL acc16_ovf: got %b required %b", ovf16_q[0], expo); end
            tests++; if (res_q[0] !== 32'h0001BE40) begin fails++; $display("FAIL acc32_sum: got %h required 0001BE40", res_q[0]); end
        end
    endtask

    task automatic test_backpressure();
        wwin_t w1, w2;
        awin_t a1, a2;
        bit s1, s2, v1, v2, ok;
        longint e1, e2;
        gen_window(w1, a1);
        gen_window(w2, a2);
        s1 = 1'($urandom_range(0, 1));
        s2 = 1'($urandom_range(0, 1));
        model_win(w1, a1, s1, 32, e1, v1);
        model_win(w2, a2, s2, 32, e2, v2);
        clear_q();
        n_acc = 0;
        i_ready = 1'b1;
        fork
            begin
                for (int b = 0; b < 16; b++) send_beat(w1[b], a1[b], s1);
                for (int b = 0; b < 16; b++) send_beat(w2[b], a2[b], s2);
            end
            begin
                int seen, guard;
                seen = 0;
                guard = 0;
                while (n_acc < 15 && guard < 400) begin @(negedge clk); guard++; end
                i_ready = 1'b0;
                guard = 0;
                while (seen < 5 && guard < 100) begin
                    @(negedge clk);
                    #1;
                    guard++;
                    if (o_valid) begin
                        seen++;
                        tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL bp_o_ready: got %b required 0", o_ready); end
                        tests++; if (o_calculated !== 32'(e1)) begin fails++; $display("FAIL bp_stable: got %h required %h", o_calculated, 32'(e1)); end
                    end
                end
                if (seen < 5) begin
                    tests++; fails++;
                    $display("FAIL bp_stall_timeout: saw %0d held cycles required 5", seen);
                end
                @(negedge clk);
                i_ready = 1'b1;
            end
        join
        idle();
        wait_results(2, ok);
        tests++; if (n_acc !== 32) begin fails++; $display("FAIL bp_beats: got %0d required 32", n_acc); end
        if (ok) begin
            tests++; if (res_q[0] !== 32'(e1)) begin fails++; $display("FAIL bp_sum1: got %h required %h", res_q[0], 32'(e1)); end
            tests++; if (res_q[1] !== 32'(e2)) begin fails++; $display("FAIL bp_sum2: got %h required %h", res_q[1], 32'(e2)); end
        end
    endtask

    task automatic test_reset_mid();
        wwin_t w;
        awin_t a;
        bit ok;
        gen_window(w, a);
        clear_q();
        for (int b = 0; b < 7; b++) send_beat(w[b], a[b], 1'b0);
        idle();
        reset_n = 1'b0;
        #1;
        tests++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin fails++; $display("FAIL midrst_outputs: ready %b valid %b required 1 0", o_ready, o_valid); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int b = 0; b < 16; b++) send_beat(16'h1111, 32'h01010101, 1'b0);
        idle();
        wait_results(1, ok);
        if (ok) begin
            tests++; if (res_q[0] !== 32'd64) begin fails++; $display("FAIL midrst_sum: got %0d required 64", res_q[0]); end
        end
        repeat (5) @(negedge clk);
        #2;
        tests++; if (res_q.size() !== 1) begin fails++; $display("FAIL midrst_count: got %0d results required 1", res_q.size()); end
    endtask

    task automatic test_clear();
        wwin_t wa, wb;
        awin_t aa, ab;
        bit sb, vb, v16, ok;
        longint eb, e16;
        gen_window(wa, aa);
        gen_window(wb, ab);
        sb = 1'($urandom_range(0, 1));
        model_win(wb, ab, sb, 32, eb, vb);
        model_win(wb, ab, sb, 16, e16, v16);
        clear_q();
        for (int b = 0; b < 8; b++) send_beat(wa[b], aa[b], 1'b1);
        @(negedge clk);
        i_valid = 1'b1;
        i_clear = 1'b1;
        i_weight = 16'hFFFF;
        i_activation = 32'hFFFFFFFF;
        #1;
        tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL clr_o_ready: got %b required 1", o_ready); end
        @(negedge clk);
        i_clear = 1'b0;
        i_valid = 1'b0;
        for (int b = 0; b < 16; b++) send_beat(wb[b], ab[b], sb);
        idle();
        wait_results(1, ok);
        if (ok) begin
            tests++; if (res_q[0] !== 32'(eb)) begin fails++; $display("FAIL clr_sum: got %h required %h", res_q[0], 32'(eb)); end
            tests++; if (res16_q[0] !== 16'(e16) || ovf16_q[0] !== v16) begin fails++; $display("FAIL clr_sum16: got %h/%b required %h/%b", res16_q[0], ovf16_q[0], 16'(e16), v16); end
        end
        repeat (4) @(negedge clk);
        #2;
        tests++; if (res_q.size() !== 1) begin fails++; $display("FAIL clr_count: got %0d results required 1", res_q.size()); end
    endtask

    task automatic test_random();
        wwin_t ws [6];
        awin_t as_ [6];
        bit sg [6];
        longint e32 [6], e16 [6];
        bit o32 [6], o16 [6];
        bit ok, done;
        for (int n = 0; n < 6; n++) begin
            gen_window(ws[n], as_[n]);
            sg[n] = 1'($urandom_range(0, 1));
            model_win(ws[n], as_[n], sg[n], 32, e32[n], o32[n]);
            model_win(ws[n], as_[n], sg[n], 16, e16[n], o16[n]);
        end
        clear_q();
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 6; n++)
                    for (int b = 0; b < 16; b++) send_beat(ws[n][b], as_[n][b], sg[n]);
                done = 1'b1;
            end
            begin
                while (1) begin
                    @(negedge clk);
                    if (done) break;
                    i_ready = ($urandom_range(0, 3) != 0);
                end
                i_ready = 1'b1;
            end
        join
        idle();
        i_ready = 1'b1;
        wait_results(6, ok);
        if (ok) begin
            for (int n = 0; n < 6; n++) begin
                tests++; if (res_q[n] !== 32'(e32[n]) || ovf_q[n] !== o32[n]) begin fails++; $display("FAIL rnd_sum32[%0d]: got %h/%b required %h/%b", n, res_q[n], ovf_q[n], 32'(e32[n]), o32[n]); end
                tests++; if (res16_q[n] !== 16'(e16[n]) || ovf16_q[n] !== o16[n]) begin fails++; $display("FAIL rnd_sum16[%0d]: got %h/%b required %h/%b", n, res16_q[n], ovf16_q[n], 16'(e16[n]), o16[n]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_ramp();
        test_signed();
        test_acc16();
        test_backpressure();
        test_reset_mid();
        test_clear();
        test_random();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
